// File: rtl/axis_pack2fifo.sv
//------------------------------------------------------------------------------
// axis_pack2fifo : packs narrow AXI4-Stream beats (first beat in MS slot) into
// wide FIFO words, aligned to SOF, honouring FIFO backpressure.
// Option: define AXIS_PACK_TLAST_FLUSH_EN to emit partial words on TLAST.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axis_pack2fifo #(
   parameter int FAW             = 8,
   parameter int AXIS_DATA_WIDTH = 32,
   parameter int AXI4_DATA_WIDTH = 128,
   parameter int FIFO_HEADROOM   = 2
) (
   input  logic                       S_AXIS_ACLK,
   input  logic                       S_AXIS_ARESETN,
   input  logic                       S_AXIS_TVALID,
   output logic                       S_AXIS_TREADY,
   input  logic [AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA,
   input  logic                       S_AXIS_TLAST,
   input  logic                       S_AXIS_USER,
   input  logic                       fwr_rdy,
   output logic                       fwr_vld,
   output logic [AXI4_DATA_WIDTH-1:0] fwr_dat,
   input  logic                       fwr_full,
   input  logic [FAW:0]               fwr_cnt,
   output logic [7:0]                 sync_err_cnt
);

   localparam int R  = AXI4_DATA_WIDTH / AXIS_DATA_WIDTH;
   localparam int SW = $clog2(R);
   localparam logic [SW-1:0]  LAST_SLOT = SW'(R - 1);
   localparam logic [FAW+1:0] CNT_LIMIT = (FAW+2)'((2 ** FAW) - FIFO_HEADROOM);

`ifdef AXIS_PACK_TLAST_FLUSH_EN
   localparam bit FLUSH_EN = 1'b1;
`else
   localparam bit FLUSH_EN = 1'b0;
`endif

   typedef enum logic [0:0] {
      SEEK = 1'b0,
      PACK = 1'b1
   } state_t;

   state_t                     state_q, state_d;
   logic [SW-1:0]              slot_q, slot_d;
   logic [AXI4_DATA_WIDTH-1:0] acc_q, acc_d;
   logic [AXI4_DATA_WIDTH-1:0] dat_q, dat_d;
   logic                       vld_q, vld_d;
   logic [7:0]                 err_q, err_d;

   logic                       space_ok;
   logic                       xfer;
   logic                       tready;
   logic                       accept;
   logic                       sof;
   logic [SW-1:0]              slot_eff;
   logic [AXI4_DATA_WIDTH-1:0] acc_ins;

   // No TVALID term here: ready depends only on state and FIFO-side inputs.
   always_comb begin
      space_ok = ({1'b0, fwr_cnt} <= CNT_LIMIT);
      xfer     = vld_q & fwr_rdy & ~fwr_full;
      tready   = S_AXIS_ARESETN &
                 ((state_q == SEEK) | (space_ok & (~vld_q | xfer)));
      accept   = S_AXIS_TVALID & tready;
      sof      = accept & S_AXIS_USER;
   end

   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      acc_d    = acc_q;
      dat_d    = dat_q;
      vld_d    = vld_q & ~xfer;
      err_d    = err_q;
      // An SOF beat always restarts the word, discarding any partial data.
      slot_eff = sof ? '0 : slot_q;
      acc_ins  = sof ? '0 : acc_q;
      acc_ins[AXI4_DATA_WIDTH - 1 - int'(slot_eff) * AXIS_DATA_WIDTH -: AXIS_DATA_WIDTH] = S_AXIS_TDATA;

      if (sof) begin
         state_d = PACK;
         if ((state_q == PACK) && (slot_q != '0) && (err_q != 8'hFF))
            err_d = err_q + 8'd1;
      end

      if (accept && (sof || (state_q == PACK))) begin
         if ((slot_eff == LAST_SLOT) || (FLUSH_EN && S_AXIS_TLAST)) begin
            dat_d  = acc_ins;
            vld_d  = 1'b1;
            acc_d  = '0;
            slot_d = '0;
         end else begin
            acc_d  = acc_ins;
            slot_d = slot_eff + 1'b1;
         end
      end
   end

   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         state_q <= SEEK;
         slot_q  <= '0;
         acc_q   <= '0;
         dat_q   <= '0;
         vld_q   <= 1'b0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         acc_q   <= acc_d;
         dat_q   <= dat_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
      end
   end

   assign S_AXIS_TREADY = tready;
   assign fwr_vld       = vld_q;
   assign fwr_dat       = dat_q;
   assign sync_err_cnt  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_pack2fifo.sv
//------------------------------------------------------------------------------
// tb_axis_pack2fifo : directed table and sequence bench for axis_pack2fifo
// (R = 4, FAW = 8, headroom 2).
//------------------------------------------------------------------------------
`default_nettype none

module tb_axis_pack2fifo;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         tvalid, tready, tlast, tuser;
   logic [31:0]  tdata;
   logic         fwr_rdy, fwr_vld, fwr_full;
   logic [127:0] fwr_dat;
   logic [8:0]   fwr_cnt;
   logic [7:0]   sync_err_cnt;

   int total = 0;
   int bad   = 0;
   logic [127:0] got[$];

   axis_pack2fifo #(
      .FAW(8), .AXIS_DATA_WIDTH(32), .AXI4_DATA_WIDTH(128), .FIFO_HEADROOM(2)
   ) dut (
      .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n),
      .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(tready), .S_AXIS_TDATA(tdata),
      .S_AXIS_TLAST(tlast), .S_AXIS_USER(tuser),
      .fwr_rdy(fwr_rdy), .fwr_vld(fwr_vld), .fwr_dat(fwr_dat),
      .fwr_full(fwr_full), .fwr_cnt(fwr_cnt), .sync_err_cnt(sync_err_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (rst_n && fwr_vld && fwr_rdy && !fwr_full) got.push_back(fwr_dat);

   typedef struct {
      logic         v; logic [31:0] d; logic u; logic l;
      logic         rdy; logic full; logic [8:0] cnt;
      logic         e_rdy; logic e_vld; logic [127:0] e_dat; logic [7:0] e_err;
   } vec_t;

   function automatic vec_t mk(input logic v, input logic [31:0] d, input logic u,
                               input logic [8:0] cnt, input logic e_rdy,
                               input logic e_vld, input logic [127:0] e_dat);
      vec_t r;
      r.v = v; r.d = d; r.u = u; r.l = 1'b0; r.rdy = 1'b1; r.full = 1'b0;
      r.cnt = cnt; r.e_rdy = e_rdy; r.e_vld = e_vld; r.e_dat = e_dat; r.e_err = 8'd0;
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d, input logic u, input logic l);
      int n;
      tvalid = 1'b1; tdata = d; tuser = u; tlast = l; n = 0;
      @(negedge clk);
      while (!tready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!tready) chk("send_timeout", 128'(tready), 128'd1);
      @(posedge clk); #1;
      tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
   endtask

   localparam logic [127:0] W1 = 128'h00000001_00000002_00000003_00000004;
   localparam logic [127:0] W2 = 128'h00000005_00000006_00000007_00000008;

   vec_t tbl[16];

   initial begin
      logic [127:0] stall_dat;
      logic [127:0] exp_w;
      int           idx;
      int           n;

      tbl[0]  = mk(1, 32'hA, 0, 0, 1, 0, 0);
      tbl[1]  = mk(1, 32'hB, 0, 0, 1, 0, 0);
      tbl[2]  = mk(1, 32'hC, 0, 0, 1, 0, 0);
      tbl[3]  = mk(1, 32'h1, 1, 0, 1, 0, 0);
      tbl[4]  = mk(1, 32'h2, 0, 0, 1, 0, 0);
      tbl[5]  = mk(1, 32'h3, 0, 0, 1, 0, 0);
      tbl[6]  = mk(1, 32'h4, 0, 0, 1, 0, 0);
      tbl[7]  = mk(1, 32'h5, 0, 0, 1, 1, W1);
      tbl[8]  = mk(1, 32'h6, 0, 0, 1, 0, W1);
      tbl[9]  = mk(1, 32'h7, 0, 0, 1, 0, W1);
      tbl[10] = mk(1, 32'h8, 0, 0, 1, 0, W1);
      tbl[11] = mk(0, 32'h0, 0, 0, 1, 1, W2);
      tbl[12] = mk(0, 32'h0, 0, 0, 1, 0, W2);
      tbl[13] = mk(0, 32'h0, 0, 255, 0, 0, W2);
      tbl[14] = mk(0, 32'h0, 0, 254, 1, 0, W2);
      tbl[15] = mk(0, 32'h0, 0, 0, 1, 0, W2);

      // reset state
      rst_n = 1'b0; tvalid = 1'b1; tdata = '0; tuser = 1'b0; tlast = 1'b0;
      fwr_rdy = 1'b1; fwr_full = 1'b0; fwr_cnt = '0;
      cycles(3);
      chk("rst_tready", 128'(tready), 128'd0);
      chk("rst_vld", 128'(fwr_vld), 128'd0);
      chk("rst_dat", fwr_dat, 128'd0);
      chk("rst_err", 128'(sync_err_cnt), 128'd0);
      tvalid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // table: pre-SOF drops, two words, headroom boundary
      for (int i = 0; i < 16; i++) begin
         tvalid = tbl[i].v; tdata = tbl[i].d; tuser = tbl[i].u; tlast = tbl[i].l;
         fwr_rdy = tbl[i].rdy; fwr_full = tbl[i].full; fwr_cnt = tbl[i].cnt;
         @(negedge clk);
         chk($sformatf("tbl%0d_tready", i), 128'(tready), 128'(tbl[i].e_rdy));
         chk($sformatf("tbl%0d_vld", i), 128'(fwr_vld), 128'(tbl[i].e_vld));
         chk($sformatf("tbl%0d_dat", i), fwr_dat, tbl[i].e_dat);
         chk($sformatf("tbl%0d_err", i), 128'(sync_err_cnt), 128'(tbl[i].e_err));
         @(posedge clk); #1;
      end
      tvalid = 1'b0; fwr_cnt = '0;
      got.delete();

      // backpressure: fwr_rdy low for 10 cycles, 12 beats offered
      fwr_rdy = 1'b0; idx = 0; stall_dat = 128'h00000011_00000012_00000013_00000014;
      for (int c = 0; c < 10; c++) begin
         tvalid = 1'b1; tdata = 32'h11 + 32'(idx); tuser = 1'b0;
         @(negedge clk);
         if (c >= 5) begin
            chk($sformatf("stall%0d_dat", c), fwr_dat, stall_dat);
            chk($sformatf("stall%0d_tready", c), 128'(tready), 128'd0);
         end
         n = tready ? 1 : 0;
         @(posedge clk); #1;
         idx += n;
      end
      chk("stall_accepted", 128'(idx), 128'd4);
      // full blocks transfer even with fwr_rdy
      fwr_rdy = 1'b1; fwr_full = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("full_vld", 128'(fwr_vld), 128'd1);
         chk("full_tready", 128'(tready), 128'd0);
         @(posedge clk); #1;
      end
      chk("full_no_xfer", 128'(got.size()), 128'd0);
      fwr_full = 1'b0;
      n = 0;
      while (idx < 12 && n < 100) begin
         tvalid = 1'b1; tdata = 32'h11 + 32'(idx);
         @(negedge clk);
         if (tready) begin
            @(posedge clk); #1; idx++;
         end else begin
            @(posedge clk); #1;
         end
         n++;
      end
      tvalid = 1'b0;
      cycles(3);
      chk("release_words", 128'(got.size()), 128'd3);
      for (int w = 0; w < 3; w++) begin
         exp_w = {32'h11 + 32'(4*w), 32'h12 + 32'(4*w), 32'h13 + 32'(4*w), 32'h14 + 32'(4*w)};
         if (w < got.size()) chk($sformatf("release_word%0d", w), got[w], exp_w);
      end
      got.delete();

      // mid-frame SOF
      send(32'h21, 1, 0); send(32'h22, 0, 0);
      send(32'h31, 1, 0); send(32'h32, 0, 0); send(32'h33, 0, 0); send(32'h34, 0, 0);
      cycles(3);
      chk("sync_err", 128'(sync_err_cnt), 128'd1);
      chk("sync_words", 128'(got.size()), 128'd1);
      if (got.size() > 0) chk("sync_word", got[0], 128'h00000031_00000032_00000033_00000034);
      got.delete();

      // TLAST on the third beat
      send(32'h1, 1, 0); send(32'h2, 0, 0); send(32'h3, 0, 1);
      cycles(3);
`ifdef AXIS_PACK_TLAST_FLUSH_EN
      chk("tlast_words", 128'(got.size()), 128'd1);
      if (got.size() > 0) chk("tlast_word", got[0], 128'h00000001_00000002_00000003_00000000);
`else
      chk("tlast_nowords", 128'(got.size()), 128'd0);
      send(32'h4, 0, 0);
      cycles(3);
      chk("tlast_words", 128'(got.size()), 128'd1);
      if (got.size() > 0) chk("tlast_word", got[0], W1);
`endif
      chk("tlast_err", 128'(sync_err_cnt), 128'd1);
      got.delete();

      // reset in mid-word
      send(32'h41, 1, 0); send(32'h42, 0, 0);
      #2 rst_n = 1'b0;
      tvalid = 1'b1; tdata = 32'h43;
      #1;
      chk("mrst_tready", 128'(tready), 128'd0);
      chk("mrst_vld", 128'(fwr_vld), 128'd0);
      chk("mrst_dat", fwr_dat, 128'd0);
      chk("mrst_err", 128'(sync_err_cnt), 128'd0);
      @(negedge clk); rst_n = 1'b1; tvalid = 1'b0;
      @(posedge clk); #1;
      send(32'h50, 0, 0);
      send(32'h51, 1, 0); send(32'h52, 0, 0); send(32'h53, 0, 0); send(32'h54, 0, 0);
      cycles(3);
      chk("mrst_words", 128'(got.size()), 128'd1);
      if (got.size() > 0) chk("mrst_word", got[0], 128'h00000051_00000052_00000053_00000054);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
